// File: rtl/swmem_pkg.sv
// Shared types and the power-on bank map for the sideways ROM/RAM controller.
// Entry layout is {valid, is_ram, wp, phys[5:0]}.
package swmem_pkg;

    typedef struct packed {
        logic       valid;
        logic       is_ram;
        logic       wp;
        logic [5:0] phys;
    } bank_entry_t;

    typedef enum logic [1:0] {
        LOAD_WAIT,
        IDLE,
        LOAD,
        FLUSH
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ROM,
        SRC_RAM
    } src_t;

    localparam int DEF_BANKS = 16;

    typedef bank_entry_t [DEF_BANKS-1:0] bank_map_t;

    // Logical 0-7 -> RAM 0-7, logical 8-14 -> ROM 0-6, 15 unused.
    function automatic bank_entry_t default_entry(input int idx);
        bank_entry_t e;
        e = '0;
        if (idx < 8) begin
            e.valid  = 1'b1;
            e.is_ram = 1'b1;
            e.phys   = 6'(idx);
        end else if (idx < 15) begin
            e.valid = 1'b1;
            e.phys  = 6'(idx - 8);
        end
        return e;
    endfunction

    function automatic bank_map_t build_default_map();
        bank_map_t m;
        for (int i = 0; i < DEF_BANKS; i++) begin
            m[i] = default_entry(i);
        end
        return m;
    endfunction

    localparam bank_map_t DEFAULT_MAP = build_default_map();

    function automatic bank_entry_t reset_entry(input int idx);
        bank_entry_t e;
        e = '0;
        if (idx < DEF_BANKS) begin
            e = DEFAULT_MAP[idx[3:0]];
        end
        return e;
    endfunction

endpackage

// File: rtl/swmem_act_timer.sv
// Activity stretcher: high while fewer than ACT_TIMEOUT cycles have passed
// since the last memory write or CPU address change.
module swmem_act_timer #(
    parameter int ACT_TIMEOUT = 2000000,
    parameter int AW          = 18
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic          pulse,
    output logic          activity
);

    localparam int CW = $clog2(ACT_TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(ACT_TIMEOUT);

    logic [AW-1:0] addr_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            cnt    <= TMAX;
        end else begin
            addr_q <= addr;
            if (pulse || addr != addr_q) begin
                cnt <= '0;
            end else if (cnt < TMAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign activity = (cnt < TMAX);

endmodule

// File: rtl/swmem_bank_ctrl.sv
// Sideways ROM/RAM bank controller with loadable map, write protect and
// HPS ROM download. Define SWMEM_ACT_LED_EN to build the activity timer.
module swmem_bank_ctrl
    import swmem_pkg::*;
#(
    parameter int NUM_BANKS   = 16,
    parameter int BANK_AW     = 14,
    parameter int ROM_BANKS   = 7,
    parameter int RAM_BANKS   = 8,
    parameter int ACT_TIMEOUT = 2000000
) (
    input  logic                                      clk_sys,
    input  logic                                      reset,
    input  logic [$clog2(NUM_BANKS)+BANK_AW-1:0]      cpu_addr,
    input  logic                                      cpu_we_n,
    input  logic [7:0]                                cpu_din,
    output logic [7:0]                                cpu_dout,
    output logic                                      cpu_hold,
    input  logic                                      map_wr,
    input  logic [$clog2(NUM_BANKS)-1:0]              map_idx,
    input  bank_entry_t                               map_entry,
    input  logic                                      ioctl_download,
    input  logic                                      ioctl_wr,
    input  logic [24:0]                               ioctl_addr,
    input  logic [7:0]                                ioctl_dout,
    output logic [$clog2(ROM_BANKS)+BANK_AW-1:0]      rom_addr,
    output logic [7:0]                                rom_din,
    output logic                                      rom_we,
    input  logic [7:0]                                rom_q,
    output logic [$clog2(RAM_BANKS)+BANK_AW-1:0]      ram_addr,
    output logic [7:0]                                ram_din,
    output logic                                      ram_we,
    input  logic [7:0]                                ram_q,
    output logic                                      wp_fault,
    output logic                                      load_ovf,
    output logic                                      activity
);

    localparam int BW     = $clog2(NUM_BANKS);
    localparam int RBW    = $clog2(ROM_BANKS);
    localparam int MBW    = $clog2(RAM_BANKS);
    localparam int ROM_AW = RBW + BANK_AW;
    localparam logic [24:0] ROM_DEPTH = 25'(ROM_BANKS) << BANK_AW;

    state_t            state, state_n;
    logic              cnt, cnt_n;
    bank_entry_t       map_q [NUM_BANKS];
    bank_entry_t       ent;
    logic [BW-1:0]     lbank;
    logic [BANK_AW-1:0] off;
    logic              rom_hit, ram_hit, wr_ok, wr_fall;
    logic              old_we;
    logic              ioctl_in;
    src_t              src, src_q;

    assign lbank    = cpu_addr[BW+BANK_AW-1:BANK_AW];
    assign off      = cpu_addr[BANK_AW-1:0];
    assign ent      = map_q[lbank];
    assign rom_hit  = ent.valid && !ent.is_ram
                      && (ent.phys < 6'(ROM_BANKS));
    assign ram_hit  = ent.valid && ent.is_ram
                      && (ent.phys < 6'(RAM_BANKS));
    assign wr_ok    = ram_hit && !ent.wp;
    assign wr_fall  = old_we && !cpu_we_n;
    assign ioctl_in = (ioctl_addr < ROM_DEPTH);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= LOAD_WAIT;
            cnt   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // cnt counts quiet cycles in LOAD_WAIT and dwell cycles in FLUSH.
    always_comb begin
        state_n = state;
        cnt_n   = 1'b0;
        unique case (state)
            LOAD_WAIT: begin
                if (!ioctl_download) begin
                    if (cnt) state_n = IDLE;
                    else     cnt_n   = 1'b1;
                end
            end
            IDLE: begin
                if (ioctl_download) state_n = LOAD;
            end
            LOAD: begin
                if (!ioctl_download) state_n = FLUSH;
            end
            FLUSH: begin
                if (cnt) state_n = IDLE;
                else     cnt_n   = 1'b1;
            end
        endcase
    end

    always_comb begin
        rom_addr = '0;
        rom_din  = '0;
        rom_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        wp_fault = 1'b0;
        src      = SRC_NONE;
        unique case (state)
            LOAD: begin
                rom_addr = ioctl_addr[ROM_AW-1:0];
                rom_din  = ioctl_dout;
                rom_we   = ioctl_wr && ioctl_in;
            end
            IDLE: begin
                rom_addr = {ent.phys[RBW-1:0], off};
                ram_addr = {ent.phys[MBW-1:0], off};
                ram_din  = cpu_din;
                ram_we   = wr_fall && wr_ok;
                wp_fault = wr_fall && !wr_ok;
                if (rom_hit)      src = SRC_ROM;
                else if (ram_hit) src = SRC_RAM;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            old_we   <= 1'b1;
            cpu_hold <= 1'b1;
            src_q    <= SRC_NONE;
            cpu_dout <= '0;
            load_ovf <= 1'b0;
        end else begin
            old_we   <= cpu_we_n;
            cpu_hold <= (state != IDLE);
            src_q    <= src;
            if (state != IDLE) begin
                cpu_dout <= '0;
            end else begin
                unique case (src_q)
                    SRC_ROM: cpu_dout <= rom_q;
                    SRC_RAM: cpu_dout <= ram_q;
                    default: cpu_dout <= '0;
                endcase
            end
            if (state == IDLE && state_n == LOAD) begin
                load_ovf <= 1'b0;
            end else if (state == LOAD && ioctl_wr && !ioctl_in) begin
                load_ovf <= 1'b1;
            end
        end
    end

    // Plain register array so the whole map resets to its boot layout.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                map_q[i] <= reset_entry(i);
            end
        end else if (map_wr) begin
            map_q[map_idx] <= map_entry;
        end
    end

`ifdef SWMEM_ACT_LED_EN
    swmem_act_timer #(
        .ACT_TIMEOUT (ACT_TIMEOUT),
        .AW          (BW + BANK_AW)
    ) u_act (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .addr     (cpu_addr),
        .pulse    (ram_we | rom_we),
        .activity (activity)
    );
`else
    logic unused_act;
    assign unused_act = ACT_TIMEOUT[0];
    assign activity   = 1'b0;
`endif

endmodule
